instr_feeder: RTL and testbench
===============================

Name: instr_feeder

Overview:
- Upstream stage of simple_processor: holds a small program RAM and drives the processor's DIN/run inputs one instruction at a time.
- Waits for the processor's done before issuing the next word.
- Replaces hand-sequenced run/DIN stimulus with a self-timed sequencer usable on board and in benches.
- A host loads the program while idle, then pulses start; the feeder reports busy/finished/error.

Parameters:
- ADDR_W, 5, program RAM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, instruction width; must match processor DIN.
- HALT_WORD, 16'hFFFF, instruction value that ends the program; it is never issued.
- TIMEOUT, 255, max cycles in WAIT without done before error; counter width is $clog2(TIMEOUT+1).

Ports:
- clk_50MHz  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- prog_we  input  1  program RAM write enable; honoured only in IDLE.
- prog_addr  input  ADDR_W  write address.
- prog_data  input  DATA_W  write data.
- prog_len  input  ADDR_W+1  number of words to run (0..DEPTH); sampled at start.
- start  input  1  one-cycle request to begin execution from address 0.
- abort  input  1  stop execution and return to IDLE.
- done  input  1  processor instruction-complete flag.
- DIN  output  DATA_W  instruction word to processor.
- run  output  1  one-cycle issue strobe, high while DIN holds a new instruction.
- pc  output  ADDR_W  address of the current or last issued word.
- busy  output  1  high in FETCH, ISSUE and WAIT.
- finished  output  1  sticky; set on normal completion.
- error  output  1  sticky; set on timeout.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; DIN=0, run=0, pc=0, busy=0, finished=0, error=0, wait counter=0. RAM contents are not cleared.
- Reset during any state forces IDLE on that edge. No run is issued on the following cycle.
- RAM: synchronous write. Read is registered: address is presented in FETCH, data is valid in ISSUE.
- IDLE: prog_we writes the RAM.
  - If start=1: latch len=prog_len, clear finished and error, pc←0.
  - If len=0: set finished and stay in IDLE. Otherwise go to FETCH.
  - start and prog_we in the same cycle: the write completes first, then start is processed.
- FETCH (1 cycle): read RAM[pc], go to ISSUE.
- ISSUE (1 cycle):
  - If word==HALT_WORD: run stays 0, set finished, go to IDLE.
  - Otherwise: DIN←word, run=1 for exactly this cycle, clear the wait counter, go to WAIT.
- Latency: start sampled at edge k; run=1 during the cycle after edge k+2.
- WAIT: run=0 and DIN is held stable. The counter increments each cycle.
  - done=1: if pc+1==len or pc==DEPTH-1, set finished and go to IDLE. Otherwise pc←pc+1 and go to FETCH.
  - Counter reaches TIMEOUT with done=0: set error, go to IDLE.
  - done=1 on the TIMEOUT cycle: done wins.
- done outside WAIT is ignored, including the ISSUE cycle.
- abort=1 in any non-IDLE state: go to IDLE next edge, run=0. finished and error are unchanged.
  - abort and done in the same cycle: abort wins; pc does not advance.
- start outside IDLE is ignored. prog_we outside IDLE is dropped.
- pc never exceeds DEPTH-1; there is no wrap-around unless FEEDER_LOOP_EN is defined.

Optional Feature:
- FEEDER_LOOP_EN defined:
  - Normal completion (len reached, or pc==DEPTH-1) sets pc←0 and goes to FETCH instead of IDLE. finished pulses for one cycle per pass rather than being sticky.
  - Execution stops only on HALT_WORD, abort, timeout, or reset.
- Undefined: behaviour is as described above. No loop logic is synthesised.

Test Plan:
- Load 0x101C (mv r0,#28), 0x0200 (mv r1,r0), 0x721B (sub r1,#27) at 0..2; prog_len=3; start; done returned 3 cycles after each run -> exactly 3 run pulses with DIN 0x101C, 0x0200, 0x721B in order; finished=1, pc=2, busy=0.
- Same program with word 1 = 0xFFFF -> one run pulse with DIN=0x101C; finished=1; no run for address 1.
- Withhold done after the first issue; TIMEOUT=255 -> error=1 exactly 255 cycles after WAIT entry; run remains 0; IDLE.
- Assert abort together with done on the second instruction -> IDLE next cycle, pc=1, no third run, finished=0.
- Assert reset_n=0 for one cycle while in WAIT -> all outputs 0 next cycle; a new start reruns from pc=0 with the RAM intact.
- prog_len=0 with start -> finished=1 with no run pulse. prog_we during WAIT -> RAM unchanged, verified by a later run.

Source files
------------

// File: rtl/instr_feeder.sv
`default_nettype none
// =============================================================================
// Module   : instr_feeder
// Brief    : Program RAM plus sequencer that issues one instruction per run
//            strobe to simple_processor and waits for done before the next.
//            Optional macro FEEDER_LOOP_EN restarts the program at address 0
//            on normal completion instead of returning to IDLE.
// Revision : 1.0 - initial release
// =============================================================================
module instr_feeder #(
   parameter int                ADDR_W    = 5,
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF,
   parameter int                TIMEOUT   = 255
) (
   input  logic              clk_50MHz,
   input  logic              reset_n,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              abort,
   input  logic              done,
   output logic [DATA_W-1:0] DIN,
   output logic              run,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              finished,
   output logic              error
);

   localparam int c_DEPTH = 2**ADDR_W;
   localparam int c_CNT_W = $clog2(TIMEOUT+1);

   localparam logic [ADDR_W-1:0]  c_PC_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]  c_PC_MAX   = ADDR_W'(c_DEPTH-1);
   localparam logic [ADDR_W:0]    c_LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t              r_state,    w_state_nxt;
   logic [ADDR_W-1:0]   r_pc,       w_pc_nxt;
   logic [ADDR_W:0]     r_len,      w_len_nxt;
   logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
   logic [DATA_W-1:0]   r_din,      w_din_nxt;
   logic                r_run,      w_run_nxt;
   logic                r_finished, w_fin_nxt;
   logic                r_error,    w_err_nxt;
   logic [DATA_W-1:0]   r_word;
   logic [DATA_W-1:0]   r_mem [c_DEPTH];
   logic                w_last;

   // Program RAM: writes only while idle; registered read launched in FETCH.
   always_ff @(posedge clk_50MHz) begin
      if (prog_we && (r_state == S_IDLE)) begin
         r_mem[prog_addr] <= prog_data;
      end
      if (r_state == S_FETCH) begin
         r_word <= r_mem[r_pc];
      end
   end

   assign w_last = (({1'b0, r_pc} + c_LEN_ONE) == r_len) || (r_pc == c_PC_MAX);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_din_nxt   = r_din;
      w_run_nxt   = 1'b0;
      w_fin_nxt   = r_finished;
      w_err_nxt   = r_error;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_len_nxt = prog_len;
               w_pc_nxt  = '0;
               w_err_nxt = 1'b0;
               if (prog_len == '0) begin
                  w_fin_nxt = 1'b1;
               end else begin
                  w_fin_nxt   = 1'b0;
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_FETCH: begin
`ifdef FEEDER_LOOP_EN
            w_fin_nxt = 1'b0;
`endif
            w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (r_word == HALT_WORD) begin
               w_fin_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_din_nxt   = r_word;
               w_run_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (done) begin
               if (w_last) begin
                  w_fin_nxt = 1'b1;
`ifdef FEEDER_LOOP_EN
                  w_pc_nxt    = '0;
                  w_state_nxt = S_FETCH;
`else
                  w_state_nxt = S_IDLE;
`endif
               end else begin
                  w_pc_nxt    = r_pc + c_PC_ONE;
                  w_state_nxt = S_FETCH;
               end
            end else if (r_cnt == c_CNT_LAST) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Abort overrides everything above, including a coincident done.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_pc_nxt    = r_pc;
         w_cnt_nxt   = r_cnt;
         w_din_nxt   = r_din;
         w_run_nxt   = 1'b0;
         w_fin_nxt   = r_finished;
         w_err_nxt   = r_error;
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_din      <= '0;
         r_run      <= 1'b0;
         r_finished <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_len      <= w_len_nxt;
         r_cnt      <= w_cnt_nxt;
         r_din      <= w_din_nxt;
         r_run      <= w_run_nxt;
         r_finished <= w_fin_nxt;
         r_error    <= w_err_nxt;
      end
   end

   assign DIN      = r_din;
   assign run      = r_run;
   assign pc       = r_pc;
   assign busy     = (r_state != S_IDLE);
   assign finished = r_finished;
   assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// =============================================================================
// Module   : tb_instr_feeder
// Brief    : Self-checking bench for instr_feeder: program table plus directed
//            timeout, abort, reset, zero-length and write-protect sequences.
// Revision : 1.0 - initial release
// =============================================================================
module tb_instr_feeder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        prog_we;
   logic [4:0]  prog_addr;
   logic [15:0] prog_data;
   logic [5:0]  prog_len;
   logic        start;
   logic        abort;
   logic        done;
   logic [15:0] DIN;
   logic        run;
   logic [4:0]  pc;
   logic        busy;
   logic        finished;
   logic        error;

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct packed {
      logic [2:0][15:0] w;
      logic [5:0]       len;
      logic [3:0]       exp_runs;
      logic [15:0]      exp_last_din;
      logic [4:0]       exp_pc;
   } vec_t;

   vec_t vecs [6];

   instr_feeder dut (
      .clk_50MHz (clk),
      .reset_n   (reset_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_len  (prog_len),
      .start     (start),
      .abort     (abort),
      .done      (done),
      .DIN       (DIN),
      .run       (run),
      .pc        (pc),
      .busy      (busy),
      .finished  (finished),
      .error     (error)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                               input logic [5:0] len, input logic [3:0] runs,
                               input logic [15:0] last, input logic [4:0] epc);
      vec_t v;
      v.w[0] = a;
      v.w[1] = b;
      v.w[2] = c;
      v.len = len;
      v.exp_runs = runs;
      v.exp_last_din = last;
      v.exp_pc = epc;
      return v;
   endfunction

   task automatic load3(input logic [2:0][15:0] w);
      for (int i = 0; i < 3; i++) begin
         prog_we   = 1'b1;
         prog_addr = 5'(i);
         prog_data = w[i];
         tick();
      end
      prog_we = 1'b0;
   endtask

   task automatic do_start(input logic [5:0] len);
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (run) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_run_timeout", 32'd0, 32'd1);
   endtask

   // Runs one program, answering each run with done three cycles later.
   task automatic run_case(input vec_t v, input bit do_load, input int id);
      int runs;
      int cd;
      if (do_load) load3(v.w);
      do_start(v.len);
      runs = 0;
      cd   = 0;
      for (int c = 0; c < 300 && busy; c++) begin
         if (run) begin
            if (runs < 3) chk($sformatf("case%0d_din%0d", id, runs), 32'(DIN), 32'(v.w[runs]));
            runs++;
            cd = 3;
         end
         done = (cd == 1);
         if (cd > 0) cd--;
         tick();
      end
      done = 1'b0;
      chk($sformatf("case%0d_busy", id), 32'(busy), 32'd0);
      chk($sformatf("case%0d_runs", id), 32'(runs), 32'(v.exp_runs));
      chk($sformatf("case%0d_pc", id), 32'(pc), 32'(v.exp_pc));
      chk($sformatf("case%0d_fin", id), 32'(finished), 32'd1);
      chk($sformatf("case%0d_err", id), 32'(error), 32'd0);
      chk($sformatf("case%0d_last_din", id), 32'(DIN), 32'(v.exp_last_din));
   endtask

   initial begin
      bit ok;
      int nruns;

      reset_n   = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      prog_len  = '0;
      start     = 1'b0;
      abort     = 1'b0;
      done      = 1'b0;

      vecs[0] = mk(16'h101C, 16'h0200, 16'h721B, 6'd3, 4'd3, 16'h721B, 5'd2);
      vecs[1] = mk(16'h101C, 16'hFFFF, 16'h721B, 6'd3, 4'd1, 16'h101C, 5'd1);
      vecs[2] = mk(16'h101C, 16'h0200, 16'h721B, 6'd2, 4'd2, 16'h0200, 5'd1);
      vecs[3] = mk(16'h101C, 16'h0200, 16'h721B, 6'd1, 4'd1, 16'h101C, 5'd0);
      vecs[4] = mk(16'hFFFF, 16'h0200, 16'h721B, 6'd3, 4'd0, 16'h101C, 5'd0);
      vecs[5] = mk(16'h0200, 16'h101C, 16'h721B, 6'd3, 4'd3, 16'h721B, 5'd2);

      repeat (3) tick();
      chk("rst_din", 32'(DIN), 32'd0);
      chk("rst_run", 32'(run), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fin", 32'(finished), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_case(vecs[i], 1'b1, i);

      // Timeout: error exactly 255 cycles after WAIT entry.
      load3(vecs[0].w);
      do_start(6'd3);
      wait_run(ok);
      nruns = 0;
      for (int i = 0; i < 254; i++) begin
         tick();
         if (run) nruns++;
      end
      chk("to_err_early", 32'(error), 32'd0);
      chk("to_busy_early", 32'(busy), 32'd1);
      tick();
      chk("to_err", 32'(error), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_run", 32'(run), 32'd0);
      chk("to_runs", 32'(nruns), 32'd0);

      // Abort together with done on the second instruction.
      do_start(6'd3);
      chk("ab_err_cleared", 32'(error), 32'd0);
      wait_run(ok);
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_run(ok);
      chk("ab_pc_second", 32'(pc), 32'd1);
      chk("ab_din_second", 32'(DIN), 32'h0200);
      abort = 1'b1;
      done  = 1'b1;
      tick();
      abort = 1'b0;
      done  = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_pc", 32'(pc), 32'd1);
      chk("ab_fin", 32'(finished), 32'd0);
      nruns = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (run) nruns++;
      end
      chk("ab_no_run", 32'(nruns), 32'd0);

      // Zero-length program finishes immediately.
      do_start(6'd0);
      chk("z_fin", 32'(finished), 32'd1);
      chk("z_busy", 32'(busy), 32'd0);
      nruns = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (run) nruns++;
      end
      chk("z_no_run", 32'(nruns), 32'd0);

      // Reset while in WAIT, then rerun with RAM intact.
      do_start(6'd3);
      wait_run(ok);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("wr_din", 32'(DIN), 32'd0);
      chk("wr_run", 32'(run), 32'd0);
      chk("wr_pc", 32'(pc), 32'd0);
      chk("wr_busy", 32'(busy), 32'd0);
      chk("wr_fin", 32'(finished), 32'd0);
      chk("wr_err", 32'(error), 32'd0);
      tick();
      chk("wr_run_after", 32'(run), 32'd0);
      run_case(vecs[0], 1'b0, 10);

      // A write during WAIT must be dropped.
      do_start(6'd3);
      wait_run(ok);
      prog_we   = 1'b1;
      prog_addr = 5'd1;
      prog_data = 16'hFFFF;
      tick();
      prog_we = 1'b0;
      abort   = 1'b1;
      tick();
      abort   = 1'b0;
      chk("we_abort_busy", 32'(busy), 32'd0);
      run_case(vecs[0], 1'b0, 11);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
